// File: rtl/regfile_8x_onehot_wr.sv
// 8 x WIDTH register file: one-hot write strobe, two registered read ports, sticky multi-hot error flag.
// Read latency 1 cycle; no backpressure, malformed strobes are dropped rather than stalled.
module regfile_8x_onehot_wr #(
   parameter int WIDTH    = 8,
   parameter bit BYPASS   = 1'b1,
   parameter bit ZERO_REG = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       wr_sel,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [2:0]       rd_addr_a,
   input  logic [2:0]       rd_addr_b,
   output logic [WIDTH-1:0] rd_data_a,
   output logic [WIDTH-1:0] rd_data_b,
   output logic             rd_valid,
   output logic             sel_err,
   output logic [7:0]       wr_count
);

   logic [WIDTH-1:0] regs [8];
   logic [7:0]       sel_low;
   logic             multi_hot;
   logic [7:0]       wr_accept;
   logic [WIDTH-1:0] next_a;
   logic [WIDTH-1:0] next_b;

   // Clearing the lowest set bit leaves something only when two or more bits are set.
   always_comb begin
      sel_low   = wr_sel & (wr_sel - 8'd1);
      multi_hot = |sel_low;
      wr_accept = multi_hot ? 8'd0 : wr_sel;
      if (ZERO_REG) begin
         wr_accept[0] = 1'b0;
      end
   end

   // Forwarding keys off the accepted strobe, so rejected or dropped writes never bypass.
   always_comb begin
      next_a = regs[rd_addr_a];
      next_b = regs[rd_addr_b];
      if (BYPASS && wr_accept[rd_addr_a]) begin
         next_a = wr_data;
      end
      if (BYPASS && wr_accept[rd_addr_b]) begin
         next_b = wr_data;
      end
      if (ZERO_REG && (rd_addr_a == 3'd0)) begin
         next_a = '0;
      end
      if (ZERO_REG && (rd_addr_b == 3'd0)) begin
         next_b = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            regs[i] <= '0;
         end
         rd_data_a <= '0;
         rd_data_b <= '0;
         rd_valid  <= 1'b0;
         sel_err   <= 1'b0;
         wr_count  <= 8'd0;
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (wr_accept[i]) begin
               regs[i] <= wr_data;
            end
         end
         if (multi_hot) begin
            sel_err <= 1'b1;
         end
         if (|wr_accept) begin
            wr_count <= wr_count + 8'd1;
         end
         rd_valid <= rd_en;
         if (rd_en) begin
            rd_data_a <= next_a;
            rd_data_b <= next_b;
         end
      end
   end

endmodule

// File: tb/tb_regfile_8x_onehot_wr.sv
// Bench for regfile_8x_onehot_wr: three configurations (bypass, no bypass, zero reg) driven in lockstep
// and checked every cycle against a behavioural model, plus directed constant checks.
module tb_regfile_8x_onehot_wr;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] wr_sel;
   logic [7:0] wr_data;
   logic       rd_en;
   logic [2:0] ra;
   logic [2:0] rb;

   logic [7:0] o_a   [3];
   logic [7:0] o_b   [3];
   logic       o_v   [3];
   logic       o_err [3];
   logic [7:0] o_cnt [3];

   logic [7:0] m_regs [3][8];
   logic [7:0] m_a    [3];
   logic [7:0] m_b    [3];
   logic       m_v    [3];
   logic       m_err  [3];
   logic [7:0] m_cnt  [3];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   regfile_8x_onehot_wr #(.WIDTH(8), .BYPASS(1'b1), .ZERO_REG(1'b0)) dut_byp (
      .clk(clk), .rst(rst), .wr_sel(wr_sel), .wr_data(wr_data), .rd_en(rd_en),
      .rd_addr_a(ra), .rd_addr_b(rb), .rd_data_a(o_a[0]), .rd_data_b(o_b[0]),
      .rd_valid(o_v[0]), .sel_err(o_err[0]), .wr_count(o_cnt[0]));

   regfile_8x_onehot_wr #(.WIDTH(8), .BYPASS(1'b0), .ZERO_REG(1'b0)) dut_nobyp (
      .clk(clk), .rst(rst), .wr_sel(wr_sel), .wr_data(wr_data), .rd_en(rd_en),
      .rd_addr_a(ra), .rd_addr_b(rb), .rd_data_a(o_a[1]), .rd_data_b(o_b[1]),
      .rd_valid(o_v[1]), .sel_err(o_err[1]), .wr_count(o_cnt[1]));

   regfile_8x_onehot_wr #(.WIDTH(8), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut_zero (
      .clk(clk), .rst(rst), .wr_sel(wr_sel), .wr_data(wr_data), .rd_en(rd_en),
      .rd_addr_a(ra), .rd_addr_b(rb), .rd_data_a(o_a[2]), .rd_data_b(o_b[2]),
      .rd_valid(o_v[2]), .sel_err(o_err[2]), .wr_count(o_cnt[2]));

   function automatic bit cfg_bp(input int c);
      return c != 1;
   endfunction

   function automatic bit cfg_zr(input int c);
      return c == 2;
   endfunction

   // Reads see the post-write register state when bypassing, the pre-write state otherwise.
   task automatic model_tick();
      for (int c = 0; c < 3; c++) begin
         if (rst) begin
            for (int r = 0; r < 8; r++) m_regs[c][r] = 8'h00;
            m_a[c] = 8'h00; m_b[c] = 8'h00; m_v[c] = 1'b0; m_err[c] = 1'b0; m_cnt[c] = 8'h00;
         end else begin
            logic [7:0] nregs [8];
            int hot;
            int idx;
            bit acc;
            hot = $countones(wr_sel);
            idx = -1;
            for (int i = 0; i < 8; i++) if (wr_sel[i]) idx = i;
            acc = (hot == 1) && !(cfg_zr(c) && idx == 0);
            for (int r = 0; r < 8; r++) nregs[r] = m_regs[c][r];
            if (acc) nregs[idx] = wr_data;
            if (rd_en) begin
               m_a[c] = (cfg_zr(c) && ra == 0) ? 8'h00 : (cfg_bp(c) ? nregs[ra] : m_regs[c][ra]);
               m_b[c] = (cfg_zr(c) && rb == 0) ? 8'h00 : (cfg_bp(c) ? nregs[rb] : m_regs[c][rb]);
            end
            m_v[c] = rd_en;
            if (hot >= 2) m_err[c] = 1'b1;
            if (acc) m_cnt[c] = (m_cnt[c] + 8'd1) % 256;
            for (int r = 0; r < 8; r++) m_regs[c][r] = nregs[r];
         end
      end
   endtask

   task automatic check(input string tag, input int c, input logic [7:0] obs, input logic [7:0] exp);
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s cfg%0d: observed %02h expected %02h", tag, c, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int c = 0; c < 3; c++) begin
         check("rd_data_a", c, o_a[c], m_a[c]);
         check("rd_data_b", c, o_b[c], m_b[c]);
         check("rd_valid", c, {7'd0, o_v[c]}, {7'd0, m_v[c]});
         check("sel_err", c, {7'd0, o_err[c]}, {7'd0, m_err[c]});
         check("wr_count", c, o_cnt[c], m_cnt[c]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_tick();
      n_vec++;
      #1;
      check_all();
   endtask

   task automatic idle();
      wr_sel = 8'h00; wr_data = 8'h00; rd_en = 1'b0; ra = 3'd0; rb = 3'd0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      for (int c = 0; c < 3; c++) begin
         for (int r = 0; r < 8; r++) m_regs[c][r] = 8'h00;
         m_a[c] = 8'h00; m_b[c] = 8'h00; m_v[c] = 1'b0; m_err[c] = 1'b0; m_cnt[c] = 8'h00;
      end
      #2;

      // Reset held two cycles, with a read request that must be ignored.
      rd_en = 1'b1;
      tick();
      tick();
      check("reset_valid", 0, {7'd0, o_v[0]}, 8'h00);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         rd_en = 1'b1; ra = 3'(i); rb = 3'(i);
         tick();
         check("reset_read", 0, o_a[0], 8'h00);
      end
      idle();

      // One-hot write sweep then crossed reads.
      for (int i = 0; i < 8; i++) begin
         wr_sel = 8'(1 << i); wr_data = 8'(8'h10 + i);
         tick();
      end
      idle();
      for (int i = 0; i < 8; i++) begin
         rd_en = 1'b1; ra = 3'(i); rb = 3'(7 - i);
         tick();
         check("sweep_a", 0, o_a[0], 8'(8'h10 + i));
         check("sweep_b", 0, o_b[0], 8'(8'h17 - i));
      end
      check("sweep_count", 0, o_cnt[0], 8'd8);
      idle();

      // Multi-hot and empty strobes.
      wr_sel = 8'b0000_0110; wr_data = 8'hFF;
      tick();
      wr_sel = 8'h00; wr_data = 8'hAA;
      tick();
      idle();
      rd_en = 1'b1; ra = 3'd1; rb = 3'd2;
      tick();
      check("malformed_reg1", 0, o_a[0], 8'h11);
      check("malformed_reg2", 0, o_b[0], 8'h12);
      check("malformed_err", 0, {7'd0, o_err[0]}, 8'h01);
      idle();
      for (int k = 0; k < 10; k++) begin
         wr_sel = 8'(1 << (4 + k % 4)); wr_data = 8'($urandom);
         tick();
      end
      check("err_sticky", 0, {7'd0, o_err[0]}, 8'h01);
      check("malformed_count", 0, o_cnt[0], 8'd18);

      // Same-cycle write and read of reg3.
      wr_sel = 8'h08; wr_data = 8'h5A; rd_en = 1'b1; ra = 3'd3; rb = 3'd3;
      tick();
      check("hazard_bypass", 0, o_a[0], 8'h5A);
      check("hazard_nobypass", 1, o_a[1], 8'h13);
      idle();
      rd_en = 1'b1; ra = 3'd3; rb = 3'd3;
      tick();
      check("hazard_after_bypass", 0, o_a[0], 8'h5A);
      check("hazard_after_nobypass", 1, o_a[1], 8'h5A);
      idle();

      // Hardwired zero register.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wr_sel = 8'h01; wr_data = 8'h77;
      tick();
      idle();
      rd_en = 1'b1; ra = 3'd0; rb = 3'd0;
      tick();
      check("zero_a", 2, o_a[2], 8'h00);
      check("zero_b", 2, o_b[2], 8'h00);
      check("zero_count", 2, o_cnt[2], 8'h00);
      check("zero_err", 2, {7'd0, o_err[2]}, 8'h00);
      check("reg0_plain", 0, o_a[0], 8'h77);
      idle();

      // Randomized traffic, including multi-hot strobes and occasional reset.
      for (int k = 0; k < 400; k++) begin
         int kind;
         kind = $urandom_range(0, 9);
         if (kind <= 5) wr_sel = 8'(1 << $urandom_range(0, 7));
         else if (kind <= 7) wr_sel = 8'h00;
         else wr_sel = 8'($urandom);
         wr_data = 8'($urandom);
         rd_en = 1'($urandom);
         ra = 3'($urandom);
         rb = 3'($urandom);
         rst = ($urandom_range(0, 39) == 0);
         tick();
      end
      rst = 1'b0;
      idle();

      // Counter wrap after 256 accepted writes, then reset colliding with read and write.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 256; k++) begin
         wr_sel = 8'(1 << (1 + k % 7)); wr_data = 8'($urandom);
         tick();
         if (k == 254) check("count_255", 0, o_cnt[0], 8'd255);
      end
      for (int c = 0; c < 3; c++) check("count_wrap", c, o_cnt[c], 8'd0);
      rst = 1'b1; rd_en = 1'b1; ra = 3'd1; rb = 3'd1; wr_sel = 8'h02; wr_data = 8'hEE;
      tick();
      check("rst_valid", 0, {7'd0, o_v[0]}, 8'h00);
      check("rst_data", 0, o_a[0], 8'h00);
      rst = 1'b0;
      idle();
      rd_en = 1'b1; ra = 3'd1; rb = 3'd1;
      tick();
      check("rst_no_commit", 0, o_a[0], 8'h00);
      check("rst_err", 0, {7'd0, o_err[0]}, 8'h00);
      idle();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
